instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_pc_reg.sv | 43 ++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch unit and the processor's
//   control unit: default bus widths and the 2-bit fetch FSM state encoding.
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int IF_ADDR_W = 8;   // instruction memory address width
  localparam int IF_DATA_W = 16;  // instruction word width (processor iin)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // no fetch in progress
    ST_FETCH = 2'b01,  // read strobe issued at PC
    ST_WAIT  = 2'b10,  // memory returns data this cycle
    ST_HOLD  = 2'b11   // word presented to processor until accepted
  } if_state_e;

  // State entered once the current word is finished (consumed or flushed):
  // keep fetching while run is high, otherwise park in IDLE.
  function automatic if_state_e resume_state(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
//   Program counter register with load and increment. Load wins over
//   increment; increment wraps modulo 2^ADDR_W.
//
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset, PC <= RESET_PC
//   i_load   in   load i_value into PC
//   i_value  in   ADDR_W  load value
//   i_inc    in   advance PC by one
//   o_pc     out  ADDR_W  current PC
// ----------------------------------------------------------------------------
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_value,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_value;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;  // natural wrap, no carry out
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit: reads words from a synchronous instruction memory
//   at PC and hands them to the processor through a valid/ready register.
//   One word in flight at a time; fixed 2-cycle latency from mem_rd to
//   iin_valid, 3 cycles per word back to back.
//
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   run        in   fetch enable (0 stops new fetches)
//   pc_load    in   jump: load pc_value, flush any word in flight
//   pc_value   in   ADDR_W  jump target
//   mem_rd     out  read strobe to instruction memory
//   mem_addr   out  ADDR_W  read address (always PC)
//   mem_rdata  in   DATA_W  read data, valid the cycle after mem_rd
//   iin        out  DATA_W  registered instruction word
//   iin_valid  out  iin holds an unconsumed word
//   iin_ready  in   processor accepts iin
//   pc         out  ADDR_W  current program counter
// ----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] iin,
  output logic              iin_valid,
  input  logic              iin_ready,
  output logic [ADDR_W-1:0] pc
);

  if_state_e         r_state;
  if_state_e         w_next_state;
  logic              w_mem_rd;
  logic              w_iin_valid;
  logic              w_capture;
  logic              w_xfer;
  logic [DATA_W-1:0] r_iin;
  logic [ADDR_W-1:0] w_pc;

  // A transfer can only happen while a word is presented.
  assign w_xfer = (r_state == ST_HOLD) && iin_ready;

  // On a jump the load dominates the increment inside pc_reg, so a transfer
  // coinciding with pc_load leaves PC at pc_value, not pc_value+1.
  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock   (clock),
    .reset   (reset),
    .i_load  (pc_load),
    .i_value (pc_value),
    .i_inc   (w_xfer),
    .o_pc    (w_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_iin_valid  = 1'b0;
    w_capture    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (run) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // run dropping here does not abort the read already issued.
        w_mem_rd     = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_capture    = 1'b1;
        w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        w_iin_valid = 1'b1;
        if (w_xfer) w_next_state = resume_state(run);
      end
      default: w_next_state = ST_IDLE;
    endcase

    // A jump flushes whatever is in flight: WAIT data is dropped and a held
    // word is withdrawn because the next state is never HOLD.
    if (pc_load) begin
      w_capture    = 1'b0;
      w_next_state = resume_state(run);
    end
  end

  // iin only changes on a capture, so it keeps its last word in IDLE, FETCH
  // and WAIT; reset clears it so the processor never sees stale contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iin <= '0;
    end else if (w_capture) begin
      r_iin <= mem_rdata;
    end
  end

  // Strobes decode straight from the state register, so reset forces them
  // low immediately along with the state.
  assign mem_rd    = w_mem_rd;
  assign mem_addr  = w_pc;
  assign iin       = r_iin;
  assign iin_valid = w_iin_valid;
  assign pc        = w_pc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        run;
  logic        pc_load;
  logic [7:0]  pc_value;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] iin;
  logic        iin_valid;
  logic        iin_ready;
  logic [7:0]  pc;

  int n_tests;
  int n_fail;
  int cyc;

  logic [15:0] mem [0:255];

  instr_fetch dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .pc_load   (pc_load),
    .pc_value  (pc_value),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .iin       (iin),
    .iin_valid (iin_valid),
    .iin_ready (iin_ready),
    .pc        (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory: data appears the cycle after the strobe.
  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    pc_load   = 1'b0;
    pc_value  = 8'h00;
    iin_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    run       = 1'b0;
    pc_load   = 1'b0;
    pc_value  = 8'h00;
    iin_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_tests++;
    if (iin !== 16'h0000) begin n_fail++; $display("FAIL reset_iin: got %h want 0000", iin); end
    n_tests++;
    if (iin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", iin_valid); end
    n_tests++;
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    reset = 1'b0;
    // run low: unit must stay idle.
    repeat (3) begin
      tick();
      n_tests++;
      if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_no_rd: got %b want 0", mem_rd); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    mem[0]    = 16'h1234;
    run       = 1'b1;
    iin_ready = 1'b1;
    tick();  // FETCH
    n_tests++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL basic_fetch: rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr);
    end
    tick();  // WAIT
    n_tests++;
    if (mem_rd !== 1'b0 || iin_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait: rd=%b valid=%b want 0 0", mem_rd, iin_valid);
    end
    tick();  // HOLD, 2 cycles after the strobe
    n_tests++;
    if (iin_valid !== 1'b1 || iin !== 16'h1234) begin
      n_fail++; $display("FAIL basic_hold: valid=%b iin=%h want 1 1234", iin_valid, iin);
    end
    tick();  // transfer taken, next fetch
    n_tests++;
    if (pc !== 8'h01 || mem_rd !== 1'b1 || mem_addr !== 8'h01) begin
      n_fail++; $display("FAIL basic_next: pc=%h rd=%b addr=%h want 01 1 01", pc, mem_rd, mem_addr);
    end
    n_tests++;
    if (iin !== 16'h1234 || iin_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_iin_kept: iin=%h valid=%b want 1234 0", iin, iin_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w0;
    do_reset();
    w0        = 16'($urandom);
    mem[0]    = w0;
    mem[1]    = ~w0;
    run       = 1'b1;
    iin_ready = 1'b0;
    repeat (3) tick();  // FETCH, WAIT, HOLD
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (iin_valid !== 1'b1 || iin !== w0 || mem_rd !== 1'b0 || pc !== 8'h00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b iin=%h rd=%b pc=%h want 1 %h 0 00",
                 i, iin_valid, iin, mem_rd, pc, w0);
      end
      tick();
    end
    iin_ready = 1'b1;
    tick();
    n_tests++;
    if (pc !== 8'h01 || mem_rd !== 1'b1 || mem_addr !== 8'h01 || iin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: pc=%h rd=%b addr=%h valid=%b want 01 1 01 0",
               pc, mem_rd, mem_addr, iin_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem[8'hFF] = 16'hAAAA;
    mem[8'h00] = 16'h5555;
    pc_load    = 1'b1;
    pc_value   = 8'hFF;
    run        = 1'b1;
    iin_ready  = 1'b1;
    tick();  // jump from IDLE straight into FETCH
    pc_load = 1'b0;
    n_tests++;
    if (pc !== 8'hFF || mem_rd !== 1'b1 || mem_addr !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_fetch_ff: pc=%h rd=%b addr=%h want ff 1 ff", pc, mem_rd, mem_addr);
    end
    repeat (2) tick();
    n_tests++;
    if (iin_valid !== 1'b1 || iin !== 16'hAAAA) begin
      n_fail++; $display("FAIL wrap_word_ff: valid=%b iin=%h want 1 aaaa", iin_valid, iin);
    end
    tick();
    n_tests++;
    if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pc: pc=%h addr=%h rd=%b want 00 00 1", pc, mem_addr, mem_rd);
    end
    repeat (2) tick();
    n_tests++;
    if (iin_valid !== 1'b1 || iin !== 16'h5555) begin
      n_fail++; $display("FAIL wrap_word_00: valid=%b iin=%h want 1 5555", iin_valid, iin);
    end
  endtask

  task automatic test_jump();
    do_reset();
    mem[8'h00] = 16'hDEAD;
    mem[8'h40] = 16'hC0DE;
    run        = 1'b1;
    iin_ready  = 1'b1;
    repeat (2) tick();  // FETCH(0), WAIT
    pc_load  = 1'b1;
    pc_value = 8'h40;
    tick();
    pc_load = 1'b0;
    n_tests++;
    if (iin_valid !== 1'b0 || iin !== 16'h0000) begin
      n_fail++; $display("FAIL jump_wait_drop: valid=%b iin=%h want 0 0000", iin_valid, iin);
    end
    n_tests++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h40 || pc !== 8'h40) begin
      n_fail++; $display("FAIL jump_refetch: rd=%b addr=%h pc=%h want 1 40 40", mem_rd, mem_addr, pc);
    end
    repeat (2) tick();
    n_tests++;
    if (iin_valid !== 1'b1 || iin !== 16'hC0DE) begin
      n_fail++; $display("FAIL jump_word: valid=%b iin=%h want 1 c0de", iin_valid, iin);
    end
    // Jump coinciding with a transfer: load wins over increment.
    pc_load  = 1'b1;
    pc_value = 8'h40;
    tick();
    pc_load = 1'b0;
    n_tests++;
    if (pc !== 8'h40 || iin_valid !== 1'b0 || mem_addr !== 8'h40) begin
      n_fail++; $display("FAIL jump_xfer_pc: pc=%h valid=%b addr=%h want 40 0 40", pc, iin_valid, mem_addr);
    end
  endtask

  task automatic test_run_drop();
    logic [15:0] w0;
    do_reset();
    w0        = 16'($urandom) | 16'h0001;
    mem[0]    = w0;
    run       = 1'b1;
    iin_ready = 1'b1;
    tick();  // FETCH
    run = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (iin_valid !== 1'b1 || iin !== w0) begin
      n_fail++; $display("FAIL rundrop_word: valid=%b iin=%h want 1 %h", iin_valid, iin, w0);
    end
    tick();  // transfer, then IDLE
    n_tests++;
    if (pc !== 8'h01 || iin_valid !== 1'b0) begin
      n_fail++; $display("FAIL rundrop_xfer: pc=%h valid=%b want 01 0", pc, iin_valid);
    end
    repeat (4) begin
      n_tests++;
      if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rundrop_idle: rd=%b want 0", mem_rd); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0]    = 16'h1111;
    mem[1]    = 16'h2222;
    mem[2]    = 16'h3333;
    run       = 1'b1;
    iin_ready = 1'b1;
    repeat (8) tick();  // two words delivered, now in WAIT at pc 2
    n_tests++;
    if (pc !== 8'h02 || iin !== 16'h2222) begin
      n_fail++; $display("FAIL rmid_pre: pc=%h iin=%h want 02 2222", pc, iin);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (pc !== 8'h00 || iin !== 16'h0000 || iin_valid !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: pc=%h iin=%h valid=%b rd=%b want 00 0000 0 0", pc, iin, iin_valid, mem_rd);
    end
    #1 reset = 1'b0;
    tick();
    n_tests++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL rmid_refetch: rd=%b addr=%h want 1 00", mem_rd, mem_addr);
    end
    iin_ready = 1'b0;
    repeat (2) tick();  // HOLD
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (iin_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_hold_valid: valid=%b want 0", iin_valid);
    end
    #1 reset = 1'b0;
  endtask

  // Transaction-level model: one word outstanding at a time, delivered 2
  // cycles after its strobe, held until accepted; jumps cancel it.
  task automatic test_random();
    logic [7:0]  exp_pc;
    logic        outstanding;
    int          issue_cyc;
    logic [15:0] exp_word;
    logic        exp_valid;
    int          delivered;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    exp_pc      = 8'h00;
    outstanding = 1'b0;
    issue_cyc   = 0;
    exp_word    = 16'h0000;
    delivered   = 0;
    for (int c = 0; c < 800; c++) begin
      n_tests++;
      if (pc !== exp_pc || mem_addr !== exp_pc) begin
        n_fail++; $display("FAIL rnd_pc c%0d: pc=%h addr=%h want %h", c, pc, mem_addr, exp_pc);
      end
      exp_valid = outstanding && (cyc >= issue_cyc + 2);
      n_tests++;
      if (iin_valid !== exp_valid) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, iin_valid, exp_valid);
      end
      if (exp_valid) begin
        n_tests++;
        if (iin !== exp_word) begin
          n_fail++; $display("FAIL rnd_word c%0d: got %h want %h", c, iin, exp_word);
        end
      end
      if (outstanding) begin
        n_tests++;
        if (mem_rd !== 1'b0) begin
          n_fail++; $display("FAIL rnd_overlap c%0d: rd=%b want 0", c, mem_rd);
        end
      end else if (mem_rd === 1'b1) begin
        outstanding = 1'b1;
        issue_cyc   = cyc;
        exp_word    = mem[exp_pc];
      end

      run       = ($urandom_range(0, 9) != 0);
      iin_ready = ($urandom_range(0, 9) < 7);
      pc_load   = ($urandom_range(0, 24) == 0);
      pc_value  = 8'($urandom);

      if (exp_valid && iin_ready) delivered++;
      if (pc_load) begin
        exp_pc      = pc_value;
        outstanding = 1'b0;
      end else if (exp_valid && iin_ready) begin
        exp_pc      = exp_pc + 8'd1;
        outstanding = 1'b0;
      end
      tick();
    end
    pc_load = 1'b0;
    n_tests++;
    if (delivered < 50) begin
      n_fail++; $display("FAIL rnd_progress: delivered %0d words, want at least 50", delivered);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    mem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_jump();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
